universal_shift_reg_n: RTL



---
 rtl/universal_shift_reg_n_pkg.sv | 19 +
 rtl/universal_shift_reg_n_if.sv | 30 +++
 rtl/universal_shift_reg_n_next_val.sv | 37 +++
 rtl/universal_shift_reg_n.sv | 111 +++++++++++
 4 files changed

// File: rtl/universal_shift_reg_n_pkg.sv
// Shared definitions for the universal shift register.
// Contents: 3-bit mode encodings (MODE_HOLD..MODE_CLEAR) and the FSM state type.
package universal_shift_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_ROR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/universal_shift_reg_n_if.sv
// Bus interface for universal_shift_reg_n.
// master: controller side (drives mode/load_data/serial inputs/start/shift_cnt,
//         observes out/ser_out_*/busy/done).
// slave:  shift register side.
interface universal_shift_reg_n_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic [2:0]       mode;
  logic [WIDTH-1:0] load_data;
  logic             ser_in_left;
  logic             ser_in_right;
  logic             start;
  logic [CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0] out;
  logic             ser_out_left;
  logic             ser_out_right;
  logic             busy;
  logic             done;

  modport master (
    output mode, load_data, ser_in_left, ser_in_right, start, shift_cnt,
    input  out, ser_out_left, ser_out_right, busy, done
  );

  modport slave (
    input  mode, load_data, ser_in_left, ser_in_right, start, shift_cnt,
    output out, ser_out_left, ser_out_right, busy, done
  );
endinterface

// File: rtl/universal_shift_reg_n_next_val.sv
// Combinational next-value function for the universal shift register.
// Ports:
//   cur_i       current register value
//   op_i        3-bit operation (MODE_* encoding)
//   load_i      parallel load value
//   ser_left_i  bit entering at MSB on right-going shifts
//   ser_right_i bit entering at LSB on left-going shifts
//   next_o      register value after applying op_i once
module usr_next_val
  import universal_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] load_i,
  input  logic             ser_left_i,
  input  logic             ser_right_i,
  output logic [WIDTH-1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    unique case (op_i)
      MODE_HOLD:  next_o = cur_i;
      MODE_SHR:   next_o = {ser_left_i, cur_i[WIDTH-1:1]};
      MODE_SHL:   next_o = {cur_i[WIDTH-2:0], ser_right_i};
      MODE_ROR:   next_o = {cur_i[0], cur_i[WIDTH-1:1]};
      MODE_ROL:   next_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
      MODE_LOAD:  next_o = load_i;
      MODE_ASR:   next_o = {cur_i[WIDTH-1], cur_i[WIDTH-1:1]};
      MODE_CLEAR: next_o = '0;
      default:    next_o = cur_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg_n.sv
// Parametrised universal shift register with counted burst operation.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    slave modport: mode, load_data, ser_in_left/right, start, shift_cnt
//          in; out, ser_out_left/right, busy, done out.
// IDLE without start applies the live mode every edge. start with a nonzero
// count latches mode/count and applies that op on the following N edges;
// start with a zero count only pulses done.
module universal_shift_reg_n
  import universal_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  universal_shift_reg_n_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       op_sel;
  logic [WIDTH-1:0] next_val;

  // During a burst the latched op drives the datapath; live mode is ignored.
  assign op_sel = (state_q == ST_RUN) ? op_q : bus.mode;

  usr_next_val #(
    .WIDTH (WIDTH)
  ) u_next_val (
    .cur_i       (data_q),
    .op_i        (op_sel),
    .load_i      (bus.load_data),
    .ser_left_i  (bus.ser_in_left),
    .ser_right_i (bus.ser_in_right),
    .next_o      (next_val)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Register is held on the start edge in both the zero and nonzero cases.
          if (bus.shift_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            op_d    = bus.mode;
            cnt_d   = bus.shift_cnt;
            busy_d  = 1'b1;
          end
        end else begin
          data_d = next_val;
        end
      end
      ST_RUN: begin
        data_d = next_val;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out           = data_q;
  assign bus.ser_out_left  = data_q[WIDTH-1];
  assign bus.ser_out_right = data_q[0];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule
